// File: rtl/stage2_if.sv
// Signal bundle around the decode stage: fetch and writeback inputs, ID/EX outputs.
interface stage2_if;
   // Fetch offers an instruction every cycle, and stage2 takes it at the edge only while
   // stall=1. ex_valid marks an ID/EX entry as real. EX never back-pressures ID/EX.
   logic [31:0] idata_in;
   logic [31:0] pc_in;
   logic [31:0] pred_in;
   logic        branch_taken;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_pred;
   logic [31:0] ex_instr;
   logic [31:0] ex_rs1_val;
   logic [31:0] ex_rs2_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic        ex_regwrite;
   logic        ex_memread;
   logic        ex_memwrite;
   logic        ex_illegal;

   modport master (
      output idata_in, pc_in, pred_in, branch_taken, wb_en, wb_rd, wb_data,
      input  stall, ex_valid, ex_pc, ex_pred, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_illegal
   );

   modport slave (
      input  idata_in, pc_in, pred_in, branch_taken, wb_en, wb_rd, wb_data,
      output stall, ex_valid, ex_pc, ex_pred, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_illegal
   );
endinterface

// File: rtl/stage2.sv
// RV32I decode stage: IF/ID register, decoder, 32x32 register file with write-through,
// load-use interlock and ID/EX register. Branch correction from EX flushes both registers.
module stage2 (
   input logic     clk,
   input logic     reset,
   stage2_if.slave bus
);
   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_OP     = 7'b0110011;
   localparam logic [6:0]  OPC_LUI    = 7'b0110111;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pred;
   } ifid_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pred;
      logic [31:0] instr;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        illegal;
   } idex_t;

   localparam ifid_t IFID_EMPTY = '{valid: 1'b0, instr: NOP, pc: 32'd0, pred: 32'd0};
   localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, pc: 32'd0, pred: 32'd0, instr: NOP,
                                     rs1_val: 32'd0, rs2_val: 32'd0, imm: 32'd0,
                                     rs1: 5'd0, rs2: 5'd0, rd: 5'd0, regwrite: 1'b0,
                                     memread: 1'b0, memwrite: 1'b0, illegal: 1'b0};

   ifid_t       id_q;
   idex_t       ex_q;
   idex_t       ex_d;
   logic [31:0] regs [32];

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] imm;
   logic        writes_rd, regwrite, memread, memwrite, uses_rs1, uses_rs2, illegal;
   logic [31:0] rs1_val, rs2_val;
   logic        hz;
   logic        stall;

   assign instr  = id_q.instr;
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'd0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      imm       = 32'd0;
      writes_rd = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin imm = imm_u; writes_rd = 1'b1; end
         OPC_JAL:            begin imm = imm_j; writes_rd = 1'b1; end
         OPC_JALR:           begin imm = imm_i; writes_rd = 1'b1; uses_rs1 = 1'b1; end
         OPC_BRANCH:         begin imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OPC_LOAD:           begin imm = imm_i; writes_rd = 1'b1; memread = 1'b1; uses_rs1 = 1'b1; end
         OPC_STORE:          begin imm = imm_s; memwrite = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OPC_OP_IMM:         begin imm = imm_i; writes_rd = 1'b1; uses_rs1 = 1'b1; end
         OPC_OP:             begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         default:            illegal = 1'b1;
      endcase
   end

   assign regwrite = writes_rd & (rd != 5'd0);

   // Write-through: a same-cycle writeback to the register being read wins over the array.
   assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                    (bus.wb_en && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                    (bus.wb_en && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   assign hz = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_q.valid &
               ((uses_rs1 & (rs1 == ex_q.rd)) | (uses_rs2 & (rs2 == ex_q.rd)));

   // stall is fetch's advance enable: a flush must let fetch load the branch target.
   assign stall = bus.branch_taken | ~hz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_q <= IFID_EMPTY;
      end else if (bus.branch_taken) begin
         id_q <= IFID_EMPTY;
      end else if (stall) begin
         id_q <= '{valid: 1'b1, instr: bus.idata_in, pc: bus.pc_in, pred: bus.pred_in};
      end
   end

   always_comb begin
      ex_d = IDEX_BUBBLE;
      if (!bus.branch_taken && !hz) begin
         ex_d.valid    = id_q.valid;
         ex_d.pc       = id_q.pc;
         ex_d.pred     = id_q.pred;
         ex_d.instr    = id_q.instr;
         ex_d.rs1_val  = rs1_val;
         ex_d.rs2_val  = rs2_val;
         ex_d.imm      = imm;
         ex_d.rs1      = rs1;
         ex_d.rs2      = rs2;
         ex_d.rd       = rd;
         ex_d.regwrite = regwrite;
         ex_d.memread  = memread;
         ex_d.memwrite = memwrite;
         ex_d.illegal  = illegal;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ex_q <= IDEX_BUBBLE;
      else       ex_q <= ex_d;
   end

   assign bus.stall       = stall;
   assign bus.ex_valid    = ex_q.valid;
   assign bus.ex_pc       = ex_q.pc;
   assign bus.ex_pred     = ex_q.pred;
   assign bus.ex_instr    = ex_q.instr;
   assign bus.ex_rs1_val  = ex_q.rs1_val;
   assign bus.ex_rs2_val  = ex_q.rs2_val;
   assign bus.ex_imm      = ex_q.imm;
   assign bus.ex_rs1      = ex_q.rs1;
   assign bus.ex_rs2      = ex_q.rs2;
   assign bus.ex_rd       = ex_q.rd;
   assign bus.ex_regwrite = ex_q.regwrite;
   assign bus.ex_memread  = ex_q.memread;
   assign bus.ex_memwrite = ex_q.memwrite;
   assign bus.ex_illegal  = ex_q.illegal;
endmodule

// File: tb/tb_stage2.sv
// Bench for stage2: directed pipeline scenarios plus random traffic, checked every cycle
// against a reference model that decodes by instruction format with plain arithmetic.
module tb_stage2;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] LW    = 32'h0000_A303;  // lw   x6,0(x1)
   localparam logic [31:0] ADD1  = 32'h0023_03B3;  // add  x7,x6,x2
   localparam logic [31:0] ADD2  = 32'h0024_03B3;  // add  x7,x8,x2
   localparam logic [31:0] ADDI  = 32'hFFD0_0293;  // addi x5,x0,-3
   localparam logic [31:0] A3    = 32'h0001_8213;  // addi x4,x3,0
   localparam logic [31:0] A0    = 32'h0000_0213;  // addi x4,x0,0
   localparam logic [31:0] BMARK = 32'hFFFF_FFFF;  // stands for "bubble" in the order queue

   typedef struct {
      logic        valid;
      logic [31:0] pc, pred, instr, rs1_val, rs2_val, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        regwrite, memread, memwrite, illegal;
      logic        uses1, uses2;
   } ex_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   stage2_if bus ();
   stage2 dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // reference model state
   ex_t         m_ex;
   logic        m_id_valid;
   logic [31:0] m_id_instr, m_id_pc, m_id_pred;
   logic [31:0] m_rf [32];
   logic        obs_stall;
   logic        exp_stall_now;
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic ex_t bubble_ex();
      ex_t b;
      b.valid = 0; b.pc = 0; b.pred = 0; b.instr = NOP; b.rs1_val = 0; b.rs2_val = 0;
      b.imm = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.regwrite = 0; b.memread = 0;
      b.memwrite = 0; b.illegal = 0; b.uses1 = 0; b.uses2 = 0;
      return b;
   endfunction

   function automatic logic [31:0] rf_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
      return m_rf[idx];
   endfunction

   function automatic ex_t ref_decode(input logic v, input logic [31:0] w,
                                      input logic [31:0] pc, input logic [31:0] pred);
      ex_t d;
      byte fmt;
      int  s;
      case (w[6:0])
         7'h37, 7'h17:        fmt = "U";
         7'h6f:               fmt = "J";
         7'h67, 7'h03, 7'h13: fmt = "I";
         7'h23:               fmt = "S";
         7'h63:               fmt = "B";
         7'h33:               fmt = "R";
         default:             fmt = "X";
      endcase
      s = w[31] ? -1 : 0;
      case (fmt)
         "I":     d.imm = 32'(s * 2048 + int'(w[30:20]));
         "S":     d.imm = 32'(s * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]));
         "B":     d.imm = 32'(s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
         "U":     d.imm = w & 32'hFFFF_F000;
         "J":     d.imm = 32'(s * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
         default: d.imm = 32'd0;
      endcase
      d.valid    = v;
      d.pc       = pc;
      d.pred     = pred;
      d.instr    = w;
      d.rs1      = w[19:15];
      d.rs2      = w[24:20];
      d.rd       = w[11:7];
      d.rs1_val  = rf_read(d.rs1);
      d.rs2_val  = rf_read(d.rs2);
      d.regwrite = (fmt inside {"U", "J", "I", "R"}) && (d.rd != 5'd0);
      d.memread  = (w[6:0] == 7'h03);
      d.memwrite = (w[6:0] == 7'h23);
      d.illegal  = (fmt == "X");
      d.uses1    = fmt inside {"I", "S", "B", "R"};
      d.uses2    = fmt inside {"S", "B", "R"};
      return d;
   endfunction

   task automatic model_reset();
      m_ex       = bubble_ex();
      m_id_valid = 1'b0;
      m_id_instr = NOP;
      m_id_pc    = 32'd0;
      m_id_pred  = 32'd0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
   endtask

   task automatic set_fetch(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] pred);
      bus.idata_in = w;
      bus.pc_in    = pc;
      bus.pred_in  = pred;
   endtask

   task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
      bus.wb_en   = en;
      bus.wb_rd   = rd;
      bus.wb_data = data;
   endtask

   // One cycle: check outputs against the model at negedge, then advance the model at posedge.
   task automatic tick();
      ex_t  dec;
      logic hz;
      @(negedge clk);
      dec = ref_decode(m_id_valid, m_id_instr, m_id_pc, m_id_pred);
      hz  = m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) && m_id_valid &&
            ((dec.uses1 && dec.rs1 == m_ex.rd) || (dec.uses2 && dec.rs2 == m_ex.rd));
      exp_stall_now = bus.branch_taken || !hz;
      obs_stall     = bus.stall;
      chk("stall", bus.stall, exp_stall_now);
      chk("ex_valid", bus.ex_valid, m_ex.valid);
      chk("ex_pc", bus.ex_pc, m_ex.pc);
      chk("ex_pred", bus.ex_pred, m_ex.pred);
      chk("ex_instr", bus.ex_instr, m_ex.instr);
      chk("ex_rs1_val", bus.ex_rs1_val, m_ex.rs1_val);
      chk("ex_rs2_val", bus.ex_rs2_val, m_ex.rs2_val);
      chk("ex_imm", bus.ex_imm, m_ex.imm);
      chk("ex_rs1", bus.ex_rs1, m_ex.rs1);
      chk("ex_rs2", bus.ex_rs2, m_ex.rs2);
      chk("ex_rd", bus.ex_rd, m_ex.rd);
      chk("ex_regwrite", bus.ex_regwrite, m_ex.regwrite);
      chk("ex_memread", bus.ex_memread, m_ex.memread);
      chk("ex_memwrite", bus.ex_memwrite, m_ex.memwrite);
      chk("ex_illegal", bus.ex_illegal, m_ex.illegal);
      @(posedge clk);
      if (bus.branch_taken) begin
         m_ex       = bubble_ex();
         m_id_valid = 1'b0;
         m_id_instr = NOP;
         m_id_pc    = 32'd0;
         m_id_pred  = 32'd0;
      end else if (hz) begin
         m_ex = bubble_ex();
      end else begin
         m_ex       = dec;
         m_id_valid = 1'b1;
         m_id_instr = bus.idata_in;
         m_id_pc    = bus.pc_in;
         m_id_pred  = bus.pred_in;
      end
      if (bus.wb_en && bus.wb_rd != 5'd0) m_rf[bus.wb_rd] = bus.wb_data;
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 11))
         0:       w[6:0] = 7'h37;
         1:       w[6:0] = 7'h17;
         2:       w[6:0] = 7'h6f;
         3:       w[6:0] = 7'h67;
         4:       w[6:0] = 7'h63;
         5, 6:    w[6:0] = 7'h03;
         7:       w[6:0] = 7'h23;
         8:       w[6:0] = 7'h13;
         9:       w[6:0] = 7'h33;
         10:      w[6:0] = 7'h0f;
         default: w[6:0] = 7'h0b;
      endcase
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          idx;
      int          stall0;
      bit          started;
      logic [31:0] prog [8];
      logic [31:0] pc;

      // clock/reset
      reset = 1'b1;
      bus.branch_taken = 1'b0;
      set_fetch(NOP, 32'd0, 32'd0);
      set_wb(1'b0, 5'd0, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_ex_valid", bus.ex_valid, 32'd0);
      chk("rst_ex_instr", bus.ex_instr, NOP);
      chk("rst_stall", bus.stall, 32'd1);
      tick();
      tick();

      // ADDI through two edges
      set_fetch(ADDI, 32'h10, 32'h14); tick();
      set_fetch(NOP, 32'h14, 32'h18);  tick();
      chk("addi_valid", bus.ex_valid, 32'd1);
      chk("addi_pc", bus.ex_pc, 32'h10);
      chk("addi_imm", bus.ex_imm, 32'hFFFF_FFFD);
      chk("addi_rd", bus.ex_rd, 32'd5);
      chk("addi_regwrite", bus.ex_regwrite, 32'd1);
      chk("addi_rs1_val", bus.ex_rs1_val, 32'd0);

      // flush of a valid IF/ID entry
      set_fetch(32'h0010_0493, 32'h20, 32'h24); tick();
      bus.branch_taken = 1'b1; set_fetch(NOP, 32'h24, 32'h28); tick();
      chk("flush_stall", obs_stall, 32'd1);
      chk("flush_ex_valid", bus.ex_valid, 32'd0);
      bus.branch_taken = 1'b0; set_fetch(NOP, 32'h80, 32'h84); tick();
      chk("flush_never_valid", bus.ex_valid, 32'd0);
      set_fetch(NOP, 32'h84, 32'h88); tick();
      chk("flush_corrected_valid", bus.ex_valid, 32'd1);
      chk("flush_corrected_pc", bus.ex_pc, 32'h80);

      // flush wins over a load-use hazard
      set_fetch(LW, 32'h100, 32'h104);   tick();
      set_fetch(ADD1, 32'h104, 32'h108); tick();
      bus.branch_taken = 1'b1; set_fetch(NOP, 32'h108, 32'h10c); tick();
      chk("prio_stall", obs_stall, 32'd1);
      chk("prio_ex_valid", bus.ex_valid, 32'd0);
      bus.branch_taken = 1'b0; set_fetch(NOP, 32'h200, 32'h204); tick();
      chk("prio_id_bubbled", bus.ex_valid, 32'd0);

      // writeback bypass, stored value and x0
      set_fetch(A3, 32'h300, 32'h304); tick();
      set_wb(1'b1, 5'd3, 32'hDEAD_BEEF); set_fetch(A0, 32'h304, 32'h308); tick();
      chk("wb_bypass", bus.ex_rs1_val, 32'hDEAD_BEEF);
      set_wb(1'b1, 5'd0, 32'h0000_1234); set_fetch(A3, 32'h308, 32'h30c); tick();
      chk("x0_same_cycle", bus.ex_rs1_val, 32'd0);
      set_wb(1'b0, 5'd0, 32'd0); set_fetch(A0, 32'h30c, 32'h310); tick();
      chk("wb_stored", bus.ex_rs1_val, 32'hDEAD_BEEF);
      set_fetch(NOP, 32'h310, 32'h314); tick();
      chk("x0_stored", bus.ex_rs1_val, 32'd0);

      // load-use: order scoreboard from the first valid ID/EX entry
      bus.branch_taken = 1'b1; tick(); bus.branch_taken = 1'b0;
      prog[0] = LW; prog[1] = ADD1; prog[2] = ADD2;
      for (int i = 3; i < 8; i++) prog[i] = NOP;
      exp_q.delete();
      exp_q.push_back(LW);
      exp_q.push_back(BMARK);
      exp_q.push_back(ADD1);
      exp_q.push_back(ADD2);
      exp_q.push_back(NOP);
      exp_q.push_back(NOP);
      idx = 0; stall0 = 0; started = 0;
      for (int c = 0; c < 12; c++) begin
         set_fetch((idx < 8) ? prog[idx] : NOP, 32'(32'h400 + 4 * idx), 32'(32'h404 + 4 * idx));
         tick();
         if (!obs_stall) stall0++;
         if (exp_stall_now) idx++;
         if (bus.ex_valid) started = 1;
         if (started && exp_q.size() > 0)
            chk("lu_order", bus.ex_valid ? bus.ex_instr : BMARK, exp_q.pop_front());
      end
      chk("lu_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("lu_stall_cycles", 32'(stall0), 32'd1);

      // random traffic
      pc = 32'h1000;
      for (int c = 0; c < 500; c++) begin
         set_fetch(rand_instr(), pc, pc + 32'd4);
         bus.branch_taken = ($urandom_range(0, 7) == 0);
         set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         tick();
         pc = pc + 32'd4;
      end
      bus.branch_taken = 1'b0;
      set_wb(1'b0, 5'd0, 32'd0);

      // asynchronous reset while the interlock holds fetch
      bus.branch_taken = 1'b1; set_fetch(NOP, 32'h500, 32'h504); tick();
      bus.branch_taken = 1'b0;
      set_fetch(LW, 32'h504, 32'h508);   tick();
      set_fetch(ADD1, 32'h508, 32'h50c); tick();
      #1 chk("pre_reset_stall", bus.stall, 32'd0);
      #1 reset = 1'b1;
      #1;
      chk("async_stall", bus.stall, 32'd1);
      chk("async_ex_valid", bus.ex_valid, 32'd0);
      chk("async_ex_instr", bus.ex_instr, NOP);
      chk("async_ex_pc", bus.ex_pc, 32'd0);
      chk("async_ex_pred", bus.ex_pred, 32'd0);
      chk("async_ex_rs1_val", bus.ex_rs1_val, 32'd0);
      chk("async_ex_rs2_val", bus.ex_rs2_val, 32'd0);
      chk("async_ex_imm", bus.ex_imm, 32'd0);
      chk("async_ex_rd", bus.ex_rd, 32'd0);
      chk("async_ex_rs1", bus.ex_rs1, 32'd0);
      chk("async_ex_rs2", bus.ex_rs2, 32'd0);
      chk("async_ex_memread", bus.ex_memread, 32'd0);
      chk("async_ex_regwrite", bus.ex_regwrite, 32'd0);
      chk("async_ex_memwrite", bus.ex_memwrite, 32'd0);
      chk("async_ex_illegal", bus.ex_illegal, 32'd0);
      model_reset();
      reset = 1'b0;

      // every register reads back zero after reset
      for (int n = 1; n < 32; n++) begin
         set_fetch({7'd0, 5'(n), 5'(n), 3'b110, 5'd0, 7'h33}, 32'(32'h600 + 4 * n), 32'(32'h604 + 4 * n));
         tick();
      end
      set_fetch(NOP, 32'h700, 32'h704);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stage2.md
# stage2

Decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage (`stage1`). It registers the fetched instruction, its PC and its predicted next address in an IF/ID register. It decodes the instruction and reads the 32×32 register file, with write-through from writeback. It detects load-use hazards, generating the fetch-stage `stall` control and inserting bubbles, and presents decoded operands and control in an ID/EX register to the execute stage. A taken-branch correction from EX flushes both internal registers.

## Interface
- `NOP`, 32'h0000_0013, instruction word held in IF/ID when it is empty.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `idata_in` in 32: instruction from fetch `idata_out`.
- `pc_in` in 32: fetch `pc`.
- `pred_in` in 32: fetch `address_predicted`.
- `branch_taken` in 1: misprediction correction from EX; flush.
- `wb_en` in 1: register-file write enable.
- `wb_rd` in 5: writeback destination register.
- `wb_data` in 32: writeback data.
- `stall` out 1: fetch control, fetch-port polarity. 1 = fetch advances or takes the branch; 0 = fetch holds PC.
- `ex_valid` out 1: ID/EX contents are a real instruction.
- `ex_pc` out 32: ID/EX PC.
- `ex_pred` out 32: ID/EX predicted address.
- `ex_instr` out 32: ID/EX instruction word.
- `ex_rs1_val` out 32: rs1 operand value.
- `ex_rs2_val` out 32: rs2 operand value.
- `ex_imm` out 32: sign-extended immediate.
- `ex_rs1` out 5, `ex_rs2` out 5, `ex_rd` out 5: register indices.
- `ex_regwrite` out 1, `ex_memread` out 1, `ex_memwrite` out 1: control bits.
- `ex_illegal` out 1: opcode not in the supported set.

## Operation
- **IF/ID register.** Holds `id_valid`, `id_instr`, `id_pc` and `id_pred`.
  - Loads `{1, idata_in, pc_in, pred_in}` when `stall`=1 and `branch_taken`=0.
  - Holds when `stall`=0.
  - On `branch_taken`, loads `{0, NOP, 0, 0}`.
- **Decode.** Operates on the IF/ID contents; the opcode is `id_instr[6:0]`.
  - Immediate by format, always sign-extended from bit 31:
    - I: LOAD, OP-IMM, JALR.
    - S: STORE.
    - B: BRANCH.
    - U: LUI, AUIPC.
    - J: JAL.
    - 0 for OP and for illegal opcodes.
  - `regwrite` = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd≠0.
  - `memread` = 1 for LOAD only; `memwrite` = 1 for STORE only.
  - `uses_rs1` for JALR, BRANCH, LOAD, STORE, OP-IMM, OP. `uses_rs2` for BRANCH, STORE, OP.
  - Any other opcode: `illegal`=1 and all control bits 0.
- **Register file.** 32×32 bits.
  - x0 always reads 0; writes with `wb_rd`=0 are ignored.
  - Written on the rising edge when `wb_en`=1.
  - Read is combinational. If `wb_en`=1, `wb_rd`≠0 and `wb_rd` equals the index being read, the read returns `wb_data` (write-through).
- **Load-use hazard.** `hz` = `ex_valid` & `ex_memread` & `ex_rd`≠0 & `id_valid` & ((`uses_rs1` & rs1==`ex_rd`) | (`uses_rs2` & rs2==`ex_rd`)).
- **`stall` output (combinational).** `stall` = `branch_taken` | !`hz`.
- **ID/EX register.**
  - Loads the decoded IF/ID contents with `ex_valid`=`id_valid` when `hz`=0 and `branch_taken`=0.
  - Loads a bubble when `hz`=1 or `branch_taken`=1. A bubble is `ex_valid`=0, all control bits 0, `ex_instr`=NOP, all other fields 0.
- **Priority.** `branch_taken` > `hz` > normal advance.

## Timing
- **Reset.**
  - Every IF/ID and ID/EX field takes its bubble value: `ex_valid`=0, `ex_instr`=NOP, everything else 0.
  - All 32 registers are cleared to 0.
  - After reset `stall`=1, since `hz`=0.
- **Latency.** An instruction on `idata_in` in cycle n appears on `ex_*` after the edge ending cycle n+1, i.e. 2 edges.
- **Load-use stall.** Costs exactly one cycle: `stall`=0 for one cycle, one bubble enters ID/EX and IF/ID holds. On the next cycle `ex_memread`=0 (bubble), so `hz` clears.
- **Flush.** `branch_taken` forces `stall`=1 in the same cycle, so fetch loads `branch_addr` at the same edge. After that edge the IF/ID and ID/EX valids are both 0, and the first corrected instruction reaches `ex_*` two edges later.
- **Simultaneous writeback and read.**
  - Same cycle: bypassed value.
  - Write at edge k, read in cycle k+1: the stored value.
- **Reset mid-stall or mid-flush.** Reset dominates asynchronously; outputs take their reset values without waiting for a clock edge.

## Test plan
- **Reset value check.** Assert `reset` asynchronously mid-cycle; all `ex_*`=0 except `ex_instr`=0x00000013; `stall`=1; x1..x31 read 0.
- **ADDI pipeline.** Feed `addi x5,x0,-3` (0xFFD00293) at pc 0x10. Two edges later: `ex_valid`=1, `ex_pc`=0x10, `ex_imm`=0xFFFFFFFD, `ex_rd`=5, `ex_regwrite`=1, `ex_rs1_val`=0.
- **Load-use stall.** Feed `lw x6,0(x1)` then `add x7,x6,x2`. Exactly one cycle with `stall`=0. One bubble (`ex_valid`=0) appears between the `lw` and the `add` on the `ex_*` outputs; the `add` is not lost or duplicated. A following `add x7,x8,x2` produces no stall.
- **Flush.** Pulse `branch_taken` while a valid instruction is in IF/ID. `stall`=1 that cycle; next cycle `ex_valid`=0 and the flushed instruction never appears with `ex_valid`=1.
- **Flush priority over hazard.** Set up a load-use hazard and `branch_taken` in the same cycle: `stall`=1 and both registers are bubbled.
- **Writeback bypass and x0.**
  - `wb_en`=1, `wb_rd`=3, `wb_data`=0xDEADBEEF in the same cycle ID reads x3: `ex_rs1_val`=0xDEADBEEF.
  - `wb_rd`=0, `wb_data`=0x1234: x0 still reads 0.
